// File: rtl/seg_display_sched.sv
// Update scheduler and refresh sequencer for the two-digit seven-segment display.
// Arbitrates byte updates, commits them only at frame ends, and sequences digits with dead-time.
module seg_display_sched #(
  parameter int REFRESH_DIV = 12000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  input  logic        blank_req,
  output logic [3:0]  nibble,
  output logic        disp_sel,
  output logic        seg_en,
  output logic [7:0]  shown,
  output logic        last_src
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  generate
    if (REFRESH_DIV < 1 || DEAD_CYCLES < 1) begin : g_bad_param
      $error("seg_display_sched: REFRESH_DIV and DEAD_CYCLES must both be >= 1");
    end
  endgenerate

  typedef enum logic {
    SHOW = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel_nxt;
  logic             frame_end;

  logic             rr;
  logic             pend_full;
  logic             pend_src;
  logic [7:0]       pend_data;
  logic [1:0]       grant;
  logic             gnt_idx;
  logic [7:0]       gnt_byte;
  logic             xfer;
  logic             commit;

  // With both requesters valid, rr names the one whose turn it is.
  function automatic logic [1:0] arb_grant(input logic [1:0] valid, input logic rr_q);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = rr_q ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt + CNT_W'(1);
    sel_nxt    = disp_sel;
    frame_end  = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          next_state = DEAD;
          cnt_nxt    = '0;
          frame_end  = disp_sel;
        end
      end
      DEAD: begin
        if (cnt == DEAD_LAST) begin
          next_state = SHOW;
          cnt_nxt    = '0;
          sel_nxt    = ~disp_sel;
        end
      end
      default: begin
        next_state = SHOW;
        cnt_nxt    = '0;
      end
    endcase
  end

  // A full buffer blocks every requester, so a transfer and a commit never share an edge.
  always_comb begin
    grant    = pend_full ? 2'b00 : arb_grant(req_valid, rr);
    gnt_idx  = grant[1];
    gnt_byte = gnt_idx ? req_data[15:8] : req_data[7:0];
    xfer     = |(req_valid & grant);
    commit   = frame_end & pend_full;
  end

  assign req_ready = grant & {2{rst_n}};
  assign nibble    = disp_sel ? shown[7:4] : shown[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SHOW;
      cnt       <= '0;
      disp_sel  <= 1'b0;
      seg_en    <= 1'b0;
      shown     <= 8'h00;
      last_src  <= 1'b0;
      rr        <= 1'b0;
      pend_full <= 1'b0;
      pend_src  <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_nxt;
      disp_sel <= sel_nxt;
      seg_en   <= (next_state == SHOW) & ~blank_req;
      if (xfer) begin
        pend_full <= 1'b1;
        pend_src  <= gnt_idx;
        rr        <= ~gnt_idx;
      end else if (commit) begin
        shown     <= pend_data;
        last_src  <= pend_src;
        pend_full <= 1'b0;
      end
    end
  end

  // Payload only; pend_full qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_data <= gnt_byte;
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched with short refresh parameters.
// Stimulus pushes hand-computed commits; a negedge monitor pops them and checks the refresh timeline.
module tb_seg_display_sched;

  localparam int RD  = 4;
  localparam int DC  = 2;
  localparam int DIG = RD + DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic        blank_req = 1'b0;
  logic [1:0]  req_ready;
  logic [3:0]  nibble;
  logic        disp_sel;
  logic        seg_en;
  logic [7:0]  shown;
  logic        last_src;

  seg_display_sched #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .blank_req (blank_req),
    .nibble    (nibble),
    .disp_sel  (disp_sel),
    .seg_en    (seg_en),
    .shown     (shown),
    .last_src  (last_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       src;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic blank_d = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle index: cycle 0 is the interval in which rst_n is released.
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
    blank_d = blank_req;
  end

  logic [8:0] prev_obs = 9'h000;
  logic [7:0] cur_shown = 8'h00;
  exp_t       mon_e;
  int         mon_ds;
  logic       mon_show;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_obs  = 9'h000;
      cur_shown = 8'h00;
    end else begin
      if ({shown, last_src} !== prev_obs) begin
        prev_obs = {shown, last_src};
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_commit: got shown=0x%0h last_src=%0d, expected no change (cycle %0d)",
                   shown, last_src, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_data", shown, mon_e.data);
          chk("commit_src", last_src, mon_e.src);
          chk("commit_cycle", cyc, mon_e.cyc);
          cur_shown = mon_e.data;
        end
      end
      mon_ds   = (cyc / DIG) % 2;
      mon_show = (cyc % DIG) < RD;
      chk("disp_sel", disp_sel, mon_ds);
      chk("seg_en", seg_en, mon_show && !blank_d);
      chk("nibble", nibble, (mon_ds != 0) ? cur_shown[7:4] : cur_shown[3:0]);
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic s, input int c);
    exp_t e;
    e.data = d;
    e.src  = s;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] v, input logic [15:0] d);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    req_valid = v;
    req_data  = d;
    blank_req = 1'b0;
    #1 chk("rst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_shown", shown, 0);
    chk("rst_last_src", last_src, 0);
    chk("rst_seg_en", seg_en, 0);
    chk("rst_disp_sel", disp_sel, 0);
    chk("rst_nibble", nibble, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single update from requester 0, committed at the first end of frame.
    do_reset(2'b00, 16'h0000);
    wait_cyc(2);
    req_data  = 16'h005A;
    req_valid = 2'b01;
    #1 chk("s1_ready", req_ready, 2'b01);
    push_exp(8'h5A, 1'b0, 10);
    wait_cyc(3);
    req_valid = 2'b00;
    wait_cyc(9);
    chk("s1_shown_hold", shown, 8'h00);
    wait_cyc(10);
    chk("s1_nibble_hi", nibble, 4'h5);
    wait_cyc(14);
    chk("s1_nibble_lo", nibble, 4'hA);

    // Round-robin with both requesters valid throughout.
    do_reset(2'b11, 16'h2211);
    chk("rr_ready0", req_ready, 2'b01);
    push_exp(8'h11, 1'b0, 10);
    push_exp(8'h22, 1'b1, 22);
    push_exp(8'h11, 1'b0, 34);
    wait_cyc(5);
    chk("rr_full", req_ready, 2'b00);
    wait_cyc(10);
    chk("rr_ready1", req_ready, 2'b10);
    wait_cyc(22);
    chk("rr_ready2", req_ready, 2'b01);
    wait_cyc(34);
    chk("rr_ready3", req_ready, 2'b10);
    req_valid = 2'b00;
    wait_cyc(36);

    // Backpressure after a requester-1 transfer; next grant goes to requester 0.
    do_reset(2'b10, 16'h3300);
    chk("bp_ready0", req_ready, 2'b10);
    push_exp(8'h33, 1'b1, 10);
    push_exp(8'h44, 1'b0, 22);
    wait_cyc(1);
    req_valid = 2'b11;
    req_data  = 16'h3344;
    for (int c = 1; c <= 9; c++) begin
      wait_cyc(c);
      #1 chk("bp_blocked", req_ready, 2'b00);
    end
    wait_cyc(10);
    chk("bp_regrant", req_ready, 2'b01);
    wait_cyc(11);
    req_valid = 2'b00;
    #1 chk("bp_full_again", req_ready, 2'b00);
    wait_cyc(24);

    // Blanking for 10 cycles mid-SHOW with a commit landing inside the window.
    do_reset(2'b00, 16'h0000);
    push_exp(8'h9C, 1'b1, 22);
    wait_cyc(13);
    blank_req = 1'b1;
    wait_cyc(14);
    chk("blank_seg_off", seg_en, 0);
    req_data  = 16'h9C00;
    req_valid = 2'b10;
    #1 chk("blank_ready", req_ready, 2'b10);
    wait_cyc(15);
    req_valid = 2'b00;
    wait_cyc(23);
    blank_req = 1'b0;
    wait_cyc(25);
    chk("blank_seg_back", seg_en, 1);
    chk("blank_shown", shown, 8'h9C);

    // Reset mid-operation discards a pending update.
    do_reset(2'b00, 16'h0000);
    wait_cyc(2);
    req_data  = 16'h0077;
    req_valid = 2'b01;
    #1 chk("mr_ready", req_ready, 2'b01);
    wait_cyc(3);
    req_valid = 2'b00;
    wait_cyc(7);
    chk("mr_pre_sel", disp_sel, 1);
    chk("mr_pre_seg", seg_en, 1);
    #1 rst_n = 1'b0;
    req_valid = 2'b01;
    #1;
    chk("mr_ready_rst", req_ready, 2'b00);
    chk("mr_sel_rst", disp_sel, 0);
    chk("mr_seg_rst", seg_en, 0);
    chk("mr_shown_rst", shown, 8'h00);
    chk("mr_src_rst", last_src, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    req_valid = 2'b00;
    wait_cyc(40);
    chk("mr_never_shown", shown, 8'h00);
    chk("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
